// File: rtl/wisc_pkg.sv
// Shared types and constants for the fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wisc_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam logic [3:0]  OPC_HLT  = 4'hF;
    localparam logic [15:0] PC_RESET = 16'h0000;

    // True when the instruction's major opcode field equals op.
    function automatic logic is_opcode(input logic [15:0] inst, input logic [3:0] op);
        return (inst[15:12] == op);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundles the memory, decode and PC-next connections of the fetch unit.
// Latency: n/a (wiring only).
// Backpressure: imem_req held until imem_ack; inst_valid held until inst_ready.
interface pc_fetch_unit_if #(
    parameter int CNT_W = 16
);
    logic             imem_req;
    logic [15:0]      imem_addr;
    logic             imem_ack;
    logic [15:0]      imem_rdata;
    logic [15:0]      inst;
    logic             inst_valid;
    logic             inst_ready;
    logic [15:0]      pc;
    logic [15:0]      next_pc;
    logic             halted;
    logic             misaligned;
    logic [CNT_W-1:0] retired;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr, inst, inst_valid, pc, halted, misaligned, retired,
        input  imem_ack, imem_rdata, inst_ready, next_pc
    );

    // Memory / decode / PC_control side.
    modport slave (
        input  imem_req, imem_addr, inst, inst_valid, pc, halted, misaligned, retired,
        output imem_ack, imem_rdata, inst_ready, next_pc
    );
endinterface

// File: rtl/pc_fetch_unit_sat_counter.sv
// Saturating up-counter for retired instructions.
// Latency: count updates on the edge where inc is sampled high.
// Backpressure: none; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Increment on request unless already saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter plus one-outstanding-request instruction fetcher with HLT/misalignment stop.
// Latency: 2 cycles per instruction minimum (ack cycle + accept cycle), +1 per wait/stall cycle.
// Backpressure: request held until ack; fetched word held in HOLD until decode accepts.
module pc_fetch_unit
    import wisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC = PC_RESET,
    parameter logic [3:0]  HALT_OP  = OPC_HLT,
    parameter int          CNT_W    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_fetch_unit_if.master bus
);
    fetch_state_t     r_state;
    logic [15:0]      r_pc;
    logic [15:0]      r_inst;
    logic             r_inst_valid;
    logic             r_halted;
    logic             r_misaligned;

    logic             w_accept;
    logic             w_is_hlt;
    logic             w_retire;
    logic [CNT_W-1:0] w_retired;

    // Decode handshake completes only in HOLD; ready outside HOLD is meaningless.
    assign w_accept = (r_state == HOLD) && bus.inst_ready;
    assign w_is_hlt = is_opcode(r_inst, HALT_OP);
    // A misaligned target still retires the instruction that produced it; HLT does not.
    assign w_retire = w_accept && !w_is_hlt;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_retired (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_retire),
        .count (w_retired)
    );

    // Fetch FSM with PC, instruction and status registers updated together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
            r_halted     <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (bus.imem_ack) begin
                        r_inst       <= bus.imem_rdata;
                        r_inst_valid <= 1'b1;
                        r_state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.inst_ready) begin
                        r_inst_valid <= 1'b0;
                        if (w_is_hlt) begin
                            r_halted <= 1'b1;
                            r_state  <= HALT;
                        end else if (bus.next_pc[0]) begin
                            r_halted     <= 1'b1;
                            r_misaligned <= 1'b1;
                            r_state      <= HALT;
                        end else begin
                            r_pc    <= bus.next_pc;
                            r_state <= FETCH;
                        end
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= HALT;
                end
            endcase
        end
    end

    // Request and address come straight from registers, so ack never loops back into them.
    assign bus.imem_req   = (r_state == FETCH);
    assign bus.imem_addr  = r_pc;
    assign bus.inst       = r_inst;
    assign bus.inst_valid = r_inst_valid;
    assign bus.pc         = r_pc;
    assign bus.halted     = r_halted;
    assign bus.misaligned = r_misaligned;
    assign bus.retired    = w_retired;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: vector table plus hand-written corner sequences.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// A second instance with a 4-bit counter exercises saturation within a short run.
module tb_pc_fetch_unit;
    import wisc_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pc_fetch_unit_if #(.CNT_W(16)) bus ();
    pc_fetch_unit_if #(.CNT_W(4))  bus2 ();

    pc_fetch_unit #(
        .RESET_PC (16'h0000),
        .HALT_OP  (4'hF),
        .CNT_W    (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pc_fetch_unit #(
        .RESET_PC (16'h0000),
        .HALT_OP  (4'hF),
        .CNT_W    (4)
    ) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] word;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int          lat;
        int          stall;
        logic [15:0] word;
        logic [15:0] npc;
        logic [15:0] exp_pc;
        logic [15:0] exp_ret;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Assert reset for part of a cycle, check the cleared state, then release.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n           = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.inst_ready  = 1'b0;
        bus.imem_rdata  = 16'h0000;
        bus.next_pc     = 16'h0000;
        #2;
        chk("rst_pc",         bus.pc,         16'h0000);
        chk("rst_inst",       bus.inst,       16'h0000);
        chk("rst_inst_valid", bus.inst_valid, 1'b0);
        chk("rst_halted",     bus.halted,     1'b0);
        chk("rst_misaligned", bus.misaligned, 1'b0);
        chk("rst_retired",    bus.retired,    16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        chk("req_after_rst",  bus.imem_req,   1'b1);
        chk("addr_after_rst", bus.imem_addr,  16'h0000);
    endtask

    // One instruction: lat wait cycles, ack, stall cycles in HOLD, then accept with npc.
    task automatic do_inst(input int lat, input int stall, input logic [15:0] word,
                           input logic [15:0] npc, output int cycles);
        logic [15:0] a0;
        sb_t         e;
        cycles = 0;
        a0 = bus.imem_addr;
        chk("req_fetch", bus.imem_req, 1'b1);
        for (int i = 0; i < lat; i++) begin
            bus.imem_ack = 1'b0;
            @(posedge clk);
            #1;
            cycles++;
            chk("addr_stable", bus.imem_addr, a0);
            chk("req_held",    bus.imem_req,  1'b1);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        sb_q.push_back('{addr: a0, word: word});
        @(posedge clk);
        #1;
        cycles++;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'hDEAD;
        chk("req_low_hold", bus.imem_req, 1'b0);
        for (int i = 0; i < stall; i++) begin
            bus.inst_ready = 1'b0;
            // Stray ack with a different word must not disturb the held instruction.
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 16'hBEEF;
            @(posedge clk);
            #1;
            cycles++;
            chk("inst_held",   bus.inst,       word);
            chk("pc_stall",    bus.pc,         a0);
            chk("valid_stall", bus.inst_valid, 1'b1);
        end
        bus.imem_ack = 1'b0;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty actual=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            chk("sb_inst",  bus.inst,       e.word);
            chk("sb_pc",    bus.pc,         e.addr);
            chk("sb_valid", bus.inst_valid, 1'b1);
        end
        bus.inst_ready = 1'b1;
        bus.next_pc    = npc;
        @(posedge clk);
        #1;
        cycles++;
        bus.inst_ready = 1'b0;
        bus.next_pc    = 16'h5555;
    endtask

    initial begin
        int cyc;
        int m;

        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 16'h0000;
        bus.inst_ready  = 1'b0;
        bus.next_pc     = 16'h0000;
        bus2.imem_ack   = 1'b0;
        bus2.imem_rdata = 16'h0000;
        bus2.inst_ready = 1'b0;
        bus2.next_pc    = 16'h0000;

        vecs[0] = '{lat: 0, stall: 0, word: 16'h1234, npc: 16'h0002, exp_pc: 16'h0002, exp_ret: 16'd1};
        vecs[1] = '{lat: 0, stall: 0, word: 16'h1234, npc: 16'h0004, exp_pc: 16'h0004, exp_ret: 16'd2};
        vecs[2] = '{lat: 0, stall: 0, word: 16'h1234, npc: 16'h0006, exp_pc: 16'h0006, exp_ret: 16'd3};
        vecs[3] = '{lat: 3, stall: 2, word: 16'h5A5A, npc: 16'h0008, exp_pc: 16'h0008, exp_ret: 16'd4};
        vecs[4] = '{lat: 1, stall: 0, word: 16'h8001, npc: 16'h0100, exp_pc: 16'h0100, exp_ret: 16'd5};
        vecs[5] = '{lat: 0, stall: 1, word: 16'h0F00, npc: 16'h0102, exp_pc: 16'h0102, exp_ret: 16'd6};

        do_reset();

        // Table-driven sequence of ordinary instructions.
        for (int v = 0; v < 6; v++) begin
            do_inst(vecs[v].lat, vecs[v].stall, vecs[v].word, vecs[v].npc, cyc);
            chk("period",     cyc,            vecs[v].lat + vecs[v].stall + 2);
            chk("pc_next",    bus.pc,         vecs[v].exp_pc);
            chk("addr_next",  bus.imem_addr,  vecs[v].exp_pc);
            chk("retired",    bus.retired,    vecs[v].exp_ret);
            chk("not_halted", bus.halted,     1'b0);
            chk("req_next",   bus.imem_req,   1'b1);
        end

        // HLT word: halts, freezes pc and count, ignores acks afterwards.
        do_inst(0, 0, 16'hF000, 16'h0104, cyc);
        chk("hlt_halted",     bus.halted,     1'b1);
        chk("hlt_pc",         bus.pc,         16'h0102);
        chk("hlt_retired",    bus.retired,    16'd6);
        chk("hlt_misaligned", bus.misaligned, 1'b0);
        chk("hlt_valid",      bus.inst_valid, 1'b0);
        for (int i = 0; i < 20; i++) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 16'h1111;
            @(posedge clk);
            #1;
            chk("hlt_req_low", bus.imem_req,   1'b0);
            chk("hlt_frozen",  bus.pc,         16'h0102);
            chk("hlt_inst",    bus.inst,       16'hF000);
            chk("hlt_stays",   bus.halted,     1'b1);
        end
        bus.imem_ack = 1'b0;

        // Odd target: halts with misaligned set, pc kept, instruction still counted.
        do_reset();
        do_inst(0, 0, 16'h1234, 16'h0103, cyc);
        chk("mis_halted",     bus.halted,     1'b1);
        chk("mis_flag",       bus.misaligned, 1'b1);
        chk("mis_pc",         bus.pc,         16'h0000);
        chk("mis_retired",    bus.retired,    16'd1);
        chk("mis_req",        bus.imem_req,   1'b0);

        // Wrap from FFFE to 0000 is an ordinary load.
        do_reset();
        do_inst(0, 0, 16'h1234, 16'hFFFE, cyc);
        chk("wrap_pre_pc", bus.pc, 16'hFFFE);
        do_inst(0, 0, 16'h1234, 16'h0000, cyc);
        chk("wrap_addr",    bus.imem_addr, 16'h0000);
        chk("wrap_req",     bus.imem_req,  1'b1);
        chk("wrap_retired", bus.retired,   16'd2);
        chk("wrap_halted",  bus.halted,    1'b0);

        // Reset pulsed while holding an instruction at pc 0040.
        do_reset();
        do_inst(0, 0, 16'h1234, 16'h0040, cyc);
        chk("mid_pre_pc", bus.pc, 16'h0040);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'h2222;
        @(posedge clk);
        #1;
        bus.imem_ack = 1'b0;
        chk("mid_hold_valid", bus.inst_valid, 1'b1);
        chk("mid_hold_inst",  bus.inst,       16'h2222);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pc",      bus.pc,         16'h0000);
        chk("mid_rst_valid",   bus.inst_valid, 1'b0);
        chk("mid_rst_retired", bus.retired,    16'h0000);
        chk("mid_rst_mis",     bus.misaligned, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        chk("mid_resume_req",  bus.imem_req,  1'b1);
        chk("mid_resume_addr", bus.imem_addr, 16'h0000);
        do_inst(0, 0, 16'h1234, 16'h0002, cyc);
        chk("mid_resume_pc",  bus.pc,      16'h0002);
        chk("mid_resume_ret", bus.retired, 16'd1);

        // Saturation on the 4-bit instance: memory always acks, decode always ready.
        do_reset();
        bus2.imem_ack   = 1'b1;
        bus2.imem_rdata = 16'h1234;
        bus2.inst_ready = 1'b1;
        m = 0;
        for (int i = 0; i < 40; i++) begin
            bus2.next_pc = bus2.pc + 16'd2;
            chk("sat_retired", {28'h0, bus2.retired}, m);
            if (bus2.inst_valid) begin
                m = (m == 15) ? 15 : m + 1;
            end
            @(posedge clk);
            #1;
        end
        chk("sat_final", {28'h0, bus2.retired}, 32'd15);
        bus2.imem_ack   = 1'b0;
        bus2.inst_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Holds the architectural program counter and fetches one 16-bit instruction per step from a variable-latency instruction memory. It sits directly upstream of the branch/PC-next logic (`PC_control`): it presents the current `pc` to that logic and loads its `next_pc` result when decode accepts the fetched instruction. It also detects HLT, flags misaligned targets and counts retired instructions.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `HALT_OP`, 4'hF, opcode in `inst[15:12]` that halts fetch
- `CNT_W`, 16, width of the retired-instruction counter
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request, held until acked
- `imem_addr`  out  16  byte address of the fetch (= `pc`)
- `imem_ack`  in  1  memory returns data this cycle
- `imem_rdata`  in  16  instruction word, valid with `imem_ack`
- `inst`  out  16  fetched instruction to decode
- `inst_valid`  out  1  `inst` is valid
- `inst_ready`  in  1  decode accepts `inst`
- `pc`  out  16  current PC, drives `PC_control` `PC_in`
- `next_pc`  in  16  from `PC_control` `PC_out`, computed combinationally from `pc`, `inst` and flags
- `halted`  out  1  fetch stopped (HLT or misalignment)
- `misaligned`  out  1  sticky: halt caused by an odd `next_pc`
- `retired`  out  CNT_W  count of accepted non-HLT instructions, saturating

## Operation
- States: FETCH, HOLD, HALT.
- Reset (async, `rst_n`=0):
  - state=FETCH, `pc`=RESET_PC, `inst`=0, `retired`=0.
  - `inst_valid`=0, `halted`=0, `misaligned`=0.
  - `imem_req`=1 from the first cycle after reset release.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_ack`: register `imem_rdata` into `inst`, go to HOLD.
  - While `imem_ack`=0: stay in FETCH and keep `imem_addr` stable.
- HOLD:
  - `inst_valid`=1, `imem_req`=0.
  - While `inst_ready`=0: hold `inst` and `pc` unchanged.
  - On `inst_valid && inst_ready`:
    - If `inst[15:12]`==HALT_OP: go to HALT, `pc` unchanged, `retired` unchanged.
    - Else if `next_pc[0]`=1: go to HALT, set `misaligned`=1, `pc` unchanged, `retired`+1.
    - Else: `pc`←`next_pc`, `retired`+1 (saturates at all-ones), go to FETCH.
- HALT:
  - `halted`=1, `inst_valid`=0, `imem_req`=0.
  - Exits only via reset. `imem_ack` is ignored.
- `imem_ack` arriving outside FETCH is ignored.
- Wrap-around: `pc`=16'hFFFE with `next_pc`=16'h0000 loads normally; there is no special case.
- The memory contract guarantees no stale ack after `rst_n` deassertion.

## Timing
- Minimum instruction period is 2 cycles:
  - cycle N: FETCH with `imem_ack`=1;
  - cycle N+1: HOLD with `inst_valid`=1 and `inst_ready`=1;
  - cycle N+2: FETCH at the new `pc`.
- Each additional cycle of memory latency or decode stall adds one cycle.
- `pc`, `inst`, `inst_valid`, `halted`, `misaligned` and `retired` are registered outputs.
- `imem_req` and `imem_addr` are decoded from the state and `pc` register only. They have no combinational path from `imem_ack`.
- `next_pc` is sampled only in the HOLD accept cycle. It must be stable during that cycle.
- `halted` rises in the cycle after the accepting edge. `retired` updates at the same edge.
- Reset asserted mid-fetch or mid-hold clears state immediately. The pending request is dropped.

## Structure
- Shared package `wisc_pkg`:
  - state enum {FETCH, HOLD, HALT};
  - `OPC_HLT` = 4'hF;
  - `PC_RESET` = 16'h0000.
- The saturating counter is a natural sub-module: `sat_counter` (parameter WIDTH; inputs `inc`, `clk`, `rst_n`).
- The FSM and PC register stay in `pc_fetch_unit`.

## Test plan
- Reset, memory with 0-cycle ack returning 16'h1234; `next_pc`=`pc`+2, `inst_ready`=1 → `imem_addr` sequence 0000, 0002, 0004 every 2 cycles; `retired` increments by 1 every 2 cycles.
- Ack delayed 3 cycles and `inst_ready` low for 2 cycles → `imem_addr` is stable for all 4 FETCH cycles; `inst`=`imem_rdata` is held during the stall; `pc` changes only at accept.
- Fetched word 16'hF000 → `halted`=1 the next cycle; `pc` frozen; `retired` unchanged; `imem_req` stays 0 for 20 further cycles.
- `next_pc`=16'h0103 at accept → `halted`=1, `misaligned`=1, `pc` unchanged.
- `pc`=16'hFFFE with `next_pc`=16'h0000 → the next `imem_addr` is 16'h0000. Separately, `retired` preloaded to 16'hFFFF plus one accept → stays 16'hFFFF.
- `rst_n` pulsed low while in HOLD with `pc`=16'h0040 → `pc`=0000, `inst_valid`=0, `retired`=0, `misaligned`=0 asynchronously; fetch resumes at 0000.
